// File: rtl/bcd_tick_counter.sv
// Four-digit BCD counter advanced by edges of a slow, asynchronous divider toggle.
// Optional build macro BCD_UPDOWN_EN adds the up_dn port and BCD decrement.
module bcd_tick_counter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          BOTH_EDGES  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        en,
    input  logic        clr,
`ifdef BCD_UPDOWN_EN
    input  logic        up_dn,
`endif
    output logic [15:0] bcd,
    output logic        tick_pulse,
    output logic        wrap
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_last;
    logic                   prev_q;
    logic [2:0]             arm_cnt_q;
    logic                   armed_q;
    logic                   strobe_d, strobe_q;
    logic [15:0]            bcd_d, bcd_q;
    logic                   pulse_d, pulse_q;
    logic                   wrap_d, wrap_q;
    logic [15:0]            inc_val;
    logic                   inc_carry;

    assign s_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q <= s_last;
        end
    end

    // Stay disarmed until both s_last and prev_q hold post-reset samples, so a
    // level already present at reset release is never mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= 3'd0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            arm_cnt_q <= arm_cnt_q + 3'd1;
            if (arm_cnt_q == 3'(SYNC_STAGES)) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_comb begin
        strobe_d = 1'b0;
        if (armed_q) begin
            strobe_d = BOTH_EDGES ? (s_last ^ prev_q) : (s_last & ~prev_q);
        end
    end

    always_comb begin
        inc_val   = bcd_q;
        inc_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

`ifdef BCD_UPDOWN_EN
    logic [15:0] dec_val;
    logic        dec_borrow;

    always_comb begin
        dec_val    = bcd_q;
        dec_borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dec_borrow) begin
                if (bcd_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end
`endif

    // clr wins over a counted strobe; a strobe seen while en is low is dropped.
    always_comb begin
        bcd_d   = bcd_q;
        pulse_d = 1'b0;
        wrap_d  = 1'b0;
        if (clr) begin
            bcd_d = 16'h0000;
        end else if (strobe_q && en) begin
            pulse_d = 1'b1;
`ifdef BCD_UPDOWN_EN
            if (up_dn) begin
                bcd_d  = inc_val;
                wrap_d = inc_carry;
            end else begin
                bcd_d  = dec_val;
                wrap_d = dec_borrow;
            end
`else
            bcd_d  = inc_val;
            wrap_d = inc_carry;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            bcd_q    <= 16'h0000;
            pulse_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            bcd_q    <= bcd_d;
            pulse_q  <= pulse_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bcd        = bcd_q;
    assign tick_pulse = pulse_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter: stimulus queues expected {bcd, wrap}
// per counted toggle, a negedge monitor pops and compares on every tick_pulse.
`timescale 1ns / 1ps
module tb_bcd_tick_counter;

    typedef struct {
        logic [15:0] bcd;
        logic        wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b1;
    logic        tick2 = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
`ifdef BCD_UPDOWN_EN
    logic        up_dn = 1'b1;
`endif
    logic [15:0] bcd, bcd2;
    logic        tick_pulse, wrap, tick_pulse2, wrap2;

    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   pulses2 = 0;
    exp_t exp_q[$];

    always #10 clk = ~clk;

    bcd_tick_counter #(.SYNC_STAGES(2), .BOTH_EDGES(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .en         (en),
        .clr        (clr),
`ifdef BCD_UPDOWN_EN
        .up_dn      (up_dn),
`endif
        .bcd        (bcd),
        .tick_pulse (tick_pulse),
        .wrap       (wrap)
    );

    bcd_tick_counter #(.SYNC_STAGES(2), .BOTH_EDGES(1'b0)) dut_rise (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick2),
        .en         (en),
        .clr        (clr),
`ifdef BCD_UPDOWN_EN
        .up_dn      (up_dn),
`endif
        .bcd        (bcd2),
        .tick_pulse (tick_pulse2),
        .wrap       (wrap2)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Decimal-integer reference model; wrap flags the 9999/0000 boundary crossing.
    task automatic push_step(input bit up);
        exp_t e;
        if (up) begin
            model_cnt = (model_cnt + 1) % 10000;
            e.wrap    = (model_cnt == 0);
        end else begin
            e.wrap    = (model_cnt == 0);
            model_cnt = (model_cnt == 0) ? 9999 : model_cnt - 1;
        end
        e.bcd = to_bcd(model_cnt);
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns four negedges later, when a counted pulse is visible.
    task automatic do_toggle(input bit counted, input bit up);
        tick_in = ~tick_in;
        if (counted) push_step(up);
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tick_pulse) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: bcd=%h wrap=%b, expected no pulse at %0t",
                             bcd, wrap, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_bcd", bcd, e.bcd);
                    chk("pulse_wrap", 16'(wrap), 16'(e.wrap));
                end
            end else begin
                chk("wrap_idle", 16'(wrap), 16'h0);
            end
            if (tick_pulse2) pulses2++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with tick_in already high; no count may result.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_bcd", bcd, 16'h0000);
        chk("reset_pulse", 16'(tick_pulse), 16'h0);
        chk("reset_wrap", 16'(wrap), 16'h0);

        // Latency: pulse appears exactly three edges after the first sampling edge.
        tick_in = ~tick_in;
        push_step(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("latency_early", 16'(tick_pulse), 16'h0);
        end
        @(negedge clk);
        chk("latency_pulse", 16'(tick_pulse), 16'h1);
        chk("latency_bcd", bcd, 16'h0001);
        @(negedge clk);
        chk("pulse_width", 16'(tick_pulse), 16'h0);

        // Carry chain through 0099, 0999 and the 9999 wrap.
        for (int n = 2; n <= 9999; n++) begin
            do_toggle(1'b1, 1'b1);
            if (n == 99)   chk("cnt_0099", bcd, 16'h0099);
            if (n == 100)  chk("cnt_0100", bcd, 16'h0100);
            if (n == 999)  chk("cnt_0999", bcd, 16'h0999);
            if (n == 1000) chk("cnt_1000", bcd, 16'h1000);
        end
        chk("cnt_9999", bcd, 16'h9999);
        do_toggle(1'b1, 1'b1);
        chk("wrap_bcd", bcd, 16'h0000);
        chk("wrap_flag", 16'(wrap), 16'h1);
        chk("wrap_pulse", 16'(tick_pulse), 16'h1);
        @(negedge clk);
        chk("wrap_single", 16'(wrap), 16'h0);
        do_toggle(1'b1, 1'b1);
        chk("after_wrap_bcd", bcd, 16'h0001);
        chk("after_wrap_flag", 16'(wrap), 16'h0);

        // clr from idle, count to 0042, then clr collides with a strobe.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_cnt = 0;
        chk("clr_idle", bcd, 16'h0000);
        for (int n = 0; n < 42; n++) do_toggle(1'b1, 1'b1);
        chk("cnt_0042", bcd, 16'h0042);
        tick_in = ~tick_in;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_strobe_bcd", bcd, 16'h0000);
        chk("clr_strobe_pulse", 16'(tick_pulse), 16'h0);
        model_cnt = 0;
        repeat (4) @(negedge clk);

        // en low: five toggles are lost.
        for (int n = 0; n < 3; n++) do_toggle(1'b1, 1'b1);
        en = 1'b0;
        for (int n = 0; n < 5; n++) do_toggle(1'b0, 1'b1);
        chk("en_low_bcd", bcd, 16'h0003);
        en = 1'b1;
        repeat (4) @(negedge clk);

        // Rising-edge-only instance: four toggles, two rising edges.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_cnt = 0;
        pulses2 = 0;
        for (int n = 0; n < 4; n++) begin
            tick2 = ~tick2;
            repeat (4) @(negedge clk);
        end
        chk("rise_only_bcd", bcd2, 16'h0002);
        chk("rise_only_pulses", 16'(pulses2), 16'h2);

`ifdef BCD_UPDOWN_EN
        up_dn = 1'b0;
        do_toggle(1'b1, 1'b0);
        chk("down_wrap_bcd", bcd, 16'h9999);
        chk("down_wrap_flag", 16'(wrap), 16'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_cnt = 0;
        up_dn = 1'b1;
        for (int n = 0; n < 100; n++) do_toggle(1'b1, 1'b1);
        up_dn = 1'b0;
        do_toggle(1'b1, 1'b0);
        chk("down_0099", bcd, 16'h0099);
        up_dn = 1'b1;
`endif

        repeat (6) @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
